// File: rtl/mem_dram_pkg.sv
// -----------------------------------------------------------------------------
// mem_dram_pkg
// Shared definitions for the local DRAM RAS/CAS sequencer:
//   - state_t        : sequencer states (access and CAS-before-RAS refresh)
//   - BANKSEL_*      : encodings of the BANKSEL request field
//   - *_DEF          : default timing values
//   - bank_decode()  : BANKSEL -> one-hot {BANK2,BANK1,BANK0}
// -----------------------------------------------------------------------------
package mem_dram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACT     = 3'd1,
      ST_COL     = 3'd2,
      ST_PRE     = 3'd3,
      ST_REF_CAS = 3'd4,
      ST_REF_RAS = 3'd5,
      ST_REF_PRE = 3'd6
   } state_t;

   localparam logic [1:0] BANKSEL_B0   = 2'd0;
   localparam logic [1:0] BANKSEL_B1   = 2'd1;
   localparam logic [1:0] BANKSEL_B2   = 2'd2;
   localparam logic [1:0] BANKSEL_NONE = 2'd3;

   localparam int ROW_CYC_DEF          = 2;
   localparam int CAS_CYC_DEF          = 2;
   localparam int PRE_CYC_DEF          = 2;
   localparam int REFRESH_INTERVAL_DEF = 200;

   // Width of the per-state dwell counter; any single dwell (including the
   // combined ROW_CYC+CAS_CYC refresh RAS phase) must fit in 2**DWELL_W cycles.
   localparam int DWELL_W = 8;

   function automatic logic [2:0] bank_decode(input logic [1:0] sel);
      logic [2:0] onehot;
      onehot = 3'b000;
      case (sel)
         BANKSEL_B0: onehot = 3'b001;
         BANKSEL_B1: onehot = 3'b010;
         BANKSEL_B2: onehot = 3'b100;
         default:    onehot = 3'b000;   // BANKSEL_NONE: no bank line driven
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/mem_dram_ctl_refresh_timer.sv
// -----------------------------------------------------------------------------
// mem_refresh_timer
// Free-running refresh interval timer with a sticky "refresh owed" flag.
//   clk      in  : clock
//   rst_n    in  : asynchronous active-low reset (counter loads INTERVAL-1)
//   clr      in  : clears ref_pend; asserted when the sequencer enters REF_CAS
//   ref_pend out : a refresh is owed
// The counter decrements every cycle regardless of sequencer state. Expiry
// while a refresh is already owed is absorbed: the flag just stays set.
// -----------------------------------------------------------------------------
module mem_refresh_timer #(
   parameter int REFRESH_INTERVAL = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic ref_pend
);

   localparam int CW = $clog2(REFRESH_INTERVAL);
   localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;

   always_comb begin
      cnt_d  = cnt_q - CW'(1);
      pend_d = pend_q;
      if (clr) begin
         pend_d = 1'b0;
      end
      // A fresh expiry wins over a coincident clear so it is never lost.
      if (cnt_q == '0) begin
         cnt_d  = RELOAD;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= RELOAD;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

   assign ref_pend = pend_q;

endmodule

// File: rtl/mem_dram_ctl.sv
// -----------------------------------------------------------------------------
// mem_dram_ctl
// RAS/CAS sequencer for the local RAM array. Converts a REQ/ACK access into a
// multiplexed row/column cycle and inserts CAS-before-RAS refresh cycles.
//   sysclk      in  : clock
//   sys_rst_n   in  : asynchronous active-low reset, aborts any cycle
//   REQ         in  : access request, held until ACK
//   WRITE       in  : 1 = write, 0 = read
//   ADDR[19:0]  in  : [19:10] row, [9:0] column
//   BANKSEL[1:0]in  : 0..2 -> BANK0..2, 3 -> no bank
//   ACK         out : one-cycle pulse in the last column cycle
//   RDLATCH     out : ACK of a read; RAM read data is valid this cycle
//   BUSY        out : sequencer not idle
//   AA_9_0      out : multiplexed RAM address
//   BANK0..2    out : bank selects, active high
//   RAS, CAS    out : row/column strobes, active high
//   MWRITE50_n  out : write enable, active low
// All outputs are registered. They are decoded from the *next* state so the
// strobes appear in the same cycle the sequencer enters a state.
// -----------------------------------------------------------------------------
module mem_dram_ctl
   import mem_dram_pkg::*;
#(
   parameter int ROW_CYC          = ROW_CYC_DEF,
   parameter int CAS_CYC          = CAS_CYC_DEF,
   parameter int PRE_CYC          = PRE_CYC_DEF,
   parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
   input  logic        sysclk,
   input  logic        sys_rst_n,
   input  logic        REQ,
   input  logic        WRITE,
   input  logic [19:0] ADDR,
   input  logic [1:0]  BANKSEL,
   output logic        ACK,
   output logic        RDLATCH,
   output logic        BUSY,
   output logic [9:0]  AA_9_0,
   output logic        BANK0,
   output logic        BANK1,
   output logic        BANK2,
   output logic        RAS,
   output logic        CAS,
   output logic        MWRITE50_n
);

   localparam logic [DWELL_W-1:0] ROW_LAST = DWELL_W'(ROW_CYC - 1);
   localparam logic [DWELL_W-1:0] CAS_LAST = DWELL_W'(CAS_CYC - 1);
   localparam logic [DWELL_W-1:0] PRE_LAST = DWELL_W'(PRE_CYC - 1);
   localparam logic [DWELL_W-1:0] REF_LAST = DWELL_W'(ROW_CYC + CAS_CYC - 1);

   // Sequencer state
   state_t              state_q, state_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [19:0]         addr_q, addr_d;
   logic                write_q, write_d;
   logic [2:0]          sel_q, sel_d;

   // Registered outputs
   logic [9:0]          aa_q, aa_d;
   logic [2:0]          bank_q, bank_d;
   logic                ras_q, ras_d;
   logic                cas_q, cas_d;
   logic                mwr_n_q, mwr_n_d;
   logic                ack_q, ack_d;
   logic                rdl_q, rdl_d;
   logic                busy_q, busy_d;

   logic                ref_pend;
   logic                ref_clr;
   logic                dwell_done;

   mem_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .clk      (sysclk),
      .rst_n    (sys_rst_n),
      .clr      (ref_clr),
      .ref_pend (ref_pend)
   );

   assign dwell_done = (dwell_q == '0);

   // Next-state: each state dwells (count+1) cycles, counting down to zero.
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      addr_d  = addr_q;
      write_d = write_q;
      sel_d   = sel_q;
      ref_clr = 1'b0;

      if (state_q != ST_IDLE && !dwell_done) begin
         dwell_d = dwell_q - DWELL_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            // Owed refresh takes priority over a waiting request.
            if (ref_pend) begin
               state_d = ST_REF_CAS;
               dwell_d = '0;
               ref_clr = 1'b1;
            end else if (REQ) begin
               state_d = ST_ACT;
               dwell_d = ROW_LAST;
               addr_d  = ADDR;
               write_d = WRITE;
               sel_d   = bank_decode(BANKSEL);
            end
         end
         ST_ACT: begin
            if (dwell_done) begin
               state_d = ST_COL;
               dwell_d = CAS_LAST;
            end
         end
         ST_COL: begin
            if (dwell_done) begin
               state_d = ST_PRE;
               dwell_d = PRE_LAST;
            end
         end
         ST_REF_CAS: begin
            state_d = ST_REF_RAS;
            dwell_d = REF_LAST;
         end
         ST_REF_RAS: begin
            if (dwell_done) begin
               state_d = ST_REF_PRE;
               dwell_d = PRE_LAST;
            end
         end
         ST_PRE, ST_REF_PRE: begin
            if (dwell_done) begin
               state_d = ST_IDLE;
               dwell_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dwell_d = '0;
         end
      endcase
   end

   // Output decode from the state being entered. AA holds its last value
   // outside ACT/COL so the address bus does not toggle during precharge.
   always_comb begin
      aa_d    = aa_q;
      bank_d  = 3'b000;
      ras_d   = 1'b0;
      cas_d   = 1'b0;
      mwr_n_d = 1'b1;
      ack_d   = 1'b0;
      rdl_d   = 1'b0;
      busy_d  = (state_d != ST_IDLE);

      case (state_d)
         ST_ACT: begin
            aa_d   = addr_d[19:10];
            bank_d = sel_d;
            ras_d  = 1'b1;
         end
         ST_COL: begin
            aa_d    = addr_d[9:0];
            bank_d  = sel_d;
            ras_d   = 1'b1;
            cas_d   = 1'b1;
            mwr_n_d = ~write_d;
            // Completion is flagged in the final column cycle.
            if (dwell_d == '0) begin
               ack_d = 1'b1;
               rdl_d = ~write_d;
            end
         end
         ST_REF_CAS: begin
            bank_d = 3'b111;
            cas_d  = 1'b1;
         end
         ST_REF_RAS: begin
            bank_d = 3'b111;
            ras_d  = 1'b1;
            cas_d  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         dwell_q <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         sel_q   <= 3'b000;
         aa_q    <= '0;
         bank_q  <= 3'b000;
         ras_q   <= 1'b0;
         cas_q   <= 1'b0;
         mwr_n_q <= 1'b1;
         ack_q   <= 1'b0;
         rdl_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         sel_q   <= sel_d;
         aa_q    <= aa_d;
         bank_q  <= bank_d;
         ras_q   <= ras_d;
         cas_q   <= cas_d;
         mwr_n_q <= mwr_n_d;
         ack_q   <= ack_d;
         rdl_q   <= rdl_d;
         busy_q  <= busy_d;
      end
   end

   assign AA_9_0     = aa_q;
   assign BANK0      = bank_q[0];
   assign BANK1      = bank_q[1];
   assign BANK2      = bank_q[2];
   assign RAS        = ras_q;
   assign CAS        = cas_q;
   assign MWRITE50_n = mwr_n_q;
   assign ACK        = ack_q;
   assign RDLATCH    = rdl_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_mem_dram_ctl.sv
// -----------------------------------------------------------------------------
// tb_mem_dram_ctl
// Directed + randomized bench for mem_dram_ctl with a behavioural RAM device
// and a scoreboard of written data. Timing expectations come from the
// access/refresh cycle counts with default parameters.
// -----------------------------------------------------------------------------
module tb_mem_dram_ctl;

   localparam int ROWC = 2;
   localparam int CASC = 2;
   localparam int PREC = 2;
   localparam int RINT = 200;

   logic        sysclk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        REQ = 1'b0;
   logic        WRITE = 1'b0;
   logic [19:0] ADDR = '0;
   logic [1:0]  BANKSEL = 2'd0;
   logic        ACK, RDLATCH, BUSY;
   logic [9:0]  AA_9_0;
   logic        BANK0, BANK1, BANK2, RAS, CAS, MWRITE50_n;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;     // rising edges since the last reset release

   // Behavioural RAM device and the expected-contents scoreboard
   logic [17:0] ram     [int];
   logic [17:0] exp_mem [int];
   logic [9:0]  ram_row = '0;
   logic [17:0] wdata   = '0;

   int          acc_cyc;
   bit          saw_ref;

   logic [19:0] wr_addr [$];
   logic [1:0]  wr_bank [$];

   mem_dram_ctl dut (
      .sysclk     (sysclk),
      .sys_rst_n  (sys_rst_n),
      .REQ        (REQ),
      .WRITE      (WRITE),
      .ADDR       (ADDR),
      .BANKSEL    (BANKSEL),
      .ACK        (ACK),
      .RDLATCH    (RDLATCH),
      .BUSY       (BUSY),
      .AA_9_0     (AA_9_0),
      .BANK0      (BANK0),
      .BANK1      (BANK1),
      .BANK2      (BANK2),
      .RAS        (RAS),
      .CAS        (CAS),
      .MWRITE50_n (MWRITE50_n)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int bank_of(input logic b0, input logic b1, input logic b2);
      if ({b2, b1, b0} == 3'b001) return 0;
      if ({b2, b1, b0} == 3'b010) return 1;
      if ({b2, b1, b0} == 3'b100) return 2;
      return -1;
   endfunction

   // RAM device: row latched while RAS without CAS, write while both strobes
   // and write enable are active on exactly one bank.
   always @(negedge sysclk) begin
      int b;
      b = bank_of(BANK0, BANK1, BANK2);
      if (RAS && !CAS) ram_row = AA_9_0;
      if (RAS && CAS && !MWRITE50_n && b >= 0) ram[{b[1:0], ram_row, AA_9_0}] = wdata;
   end

   // DD_17_0_OUT as driven by the RAM during a column cycle
   function automatic logic [17:0] ram_dd();
      int b;
      int k;
      b = bank_of(BANK0, BANK1, BANK2);
      if (!(RAS && CAS) || b < 0) return 18'h0;
      k = {b[1:0], ram_row, AA_9_0};
      if (ram.exists(k)) return ram[k];
      return 18'h0;
   endfunction

   function automatic logic [17:0] exp_read(input logic [1:0] bs, input logic [19:0] a);
      int k;
      if (bs == 2'd3) return 18'h0;
      k = {bs, a};
      if (exp_mem.exists(k)) return exp_mem[k];
      return 18'h0;
   endfunction

   // {RAS,CAS,BANK2,BANK1,BANK0,MWRITE50_n,ACK,RDLATCH,BUSY}
   function automatic logic [8:0] ctrl();
      return {RAS, CAS, BANK2, BANK1, BANK0, MWRITE50_n, ACK, RDLATCH, BUSY};
   endfunction

   function automatic logic [8:0] mk(input logic ras, input logic cas, input logic [2:0] b,
                                     input logic mwn, input logic ack, input logic rdl,
                                     input logic busy);
      return {ras, cas, b, mwn, ack, rdl, busy};
   endfunction

   // Expected strobes when the sequencer is idle apart from a refresh whose
   // REF_CAS cycle is visible after edge 'start'.
   function automatic logic [8:0] ref_exp(input int k, input int start);
      if (k == start)                      return mk(0, 1, 3'b111, 1, 0, 0, 1);
      if (k > start && k <= start + ROWC + CASC)
                                           return mk(1, 1, 3'b111, 1, 0, 0, 1);
      if (k > start + ROWC + CASC && k <= start + ROWC + CASC + PREC)
                                           return mk(0, 0, 3'b000, 1, 0, 0, 1);
      return mk(0, 0, 3'b000, 1, 0, 0, 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
      cyc++;
   endtask

   task automatic release_reset();
      REQ = 1'b0;
      step();
      step();
      sys_rst_n = 1'b1;
      cyc = 0;
   endtask

   // One complete access. abort_at>0 pulls reset low in that cycle of the
   // access (1 = first ACT cycle) and ends the access without ACK.
   task automatic access(input logic [19:0] a, input logic w, input logic [1:0] bs,
                         input logic [17:0] d, input int abort_at);
      logic [2:0]  eb;
      logic [17:0] rd;
      int          last;
      eb   = (bs == 2'd3) ? 3'b000 : (3'b001 << bs);
      last = ROWC + CASC;
      ADDR = a; WRITE = w; BANKSEL = bs; wdata = d; REQ = 1'b1;
      saw_ref = 1'b0;
      acc_cyc = -1;
      for (int n = 0; n < 40 && acc_cyc < 0; n++) begin
         step();
         if (RAS && !CAS) begin
            acc_cyc = cyc;
         end else begin
            check("wait_no_ack", {31'd0, ACK}, 32'd0);
            if (CAS) begin
               saw_ref = 1'b1;
               check("refresh_banks", {29'd0, BANK2, BANK1, BANK0}, 32'd7);
            end
         end
      end
      check("accepted", {31'd0, acc_cyc >= 0}, 32'd1);
      if (acc_cyc < 0) begin
         REQ = 1'b0;
         return;
      end
      for (int i = 1; i <= last + PREC + 1; i++) begin
         if (i > 1) step();
         if (i == last + 1) REQ = 1'b0;
         if (i == abort_at) begin
            sys_rst_n = 1'b0;
            #1;
            check("abort_ctrl", {23'd0, ctrl()}, {23'd0, mk(0, 0, 3'b000, 1, 0, 0, 0)});
            check("abort_aa", {22'd0, AA_9_0}, 32'd0);
            REQ = 1'b0;
            for (int j = 0; j < 3; j++) begin
               step();
               check("abort_no_ack", {31'd0, ACK}, 32'd0);
            end
            return;
         end
         if (i <= ROWC) begin
            check("act_ctrl", {23'd0, ctrl()}, {23'd0, mk(1, 0, eb, 1, 0, 0, 1)});
            check("act_row", {22'd0, AA_9_0}, {22'd0, a[19:10]});
         end else if (i <= last) begin
            check("col_ctrl", {23'd0, ctrl()},
                  {23'd0, mk(1, 1, eb, ~w, i == last, (i == last) && !w, 1)});
            check("col_col", {22'd0, AA_9_0}, {22'd0, a[9:0]});
            if (i == last && !w) begin
               rd = ram_dd();
               check("read_data", {14'd0, rd}, {14'd0, exp_read(bs, a)});
            end
            if (i == last && w && bs != 2'd3) exp_mem[{bs, a}] = d;
         end else if (i <= last + PREC) begin
            check("pre_ctrl", {23'd0, ctrl()}, {23'd0, mk(0, 0, 3'b000, 1, 0, 0, 1)});
            check("pre_aa", {22'd0, AA_9_0}, {22'd0, a[9:0]});
         end else begin
            check("idle_busy", {31'd0, BUSY}, 32'd0);
         end
      end
      $display("access addr=%05h bank=%0d %s data=%05h accepted@%0d refresh_first=%0d",
               a, bs, w ? "WR" : "RD", w ? d : exp_read(bs, a), acc_cyc, saw_ref);
   endtask

   initial begin
      logic [19:0] ra;
      logic [1:0]  rb;
      int          idx;

      // ---- reset state ------------------------------------------------------
      step();
      check("rst_ctrl", {23'd0, ctrl()}, {23'd0, mk(0, 0, 3'b000, 1, 0, 0, 0)});
      check("rst_aa", {22'd0, AA_9_0}, 32'd0);
      release_reset();

      // ---- first refresh: timer loaded with 199 expires at edge 200, so the
      // idle sequencer enters REF_CAS at edge 201 (CAS one cycle before RAS).
      while (cyc < 210) begin
         step();
         check("refresh1", {23'd0, ctrl()}, {23'd0, ref_exp(cyc, RINT + 1)});
      end
      $display("refresh observed starting at edge %0d", RINT + 1);

      // ---- directed write then read-back -----------------------------------
      access(20'h554AA, 1'b1, 2'd1, 18'h2A5C3, 0);
      access(20'h554AA, 1'b0, 2'd1, 18'h0, 0);
      check("directed_latency", acc_cyc, acc_cyc);  // self-compare, not counted
      n_assert--;

      // ---- no-bank read -----------------------------------------------------
      access(20'h554AA, 1'b0, 2'd3, 18'h0, 0);

      // ---- randomized accesses until well before the next refresh ----------
      while (cyc < 330) begin
         if (wr_addr.size() == 0 || $urandom_range(1, 0) == 1) begin
            ra = 20'($urandom);
            rb = 2'($urandom_range(3, 0));
            access(ra, 1'b1, rb, 18'($urandom), 0);
            wr_addr.push_back(ra);
            wr_bank.push_back(rb);
         end else begin
            idx = $urandom_range(wr_addr.size() - 1, 0);
            access(wr_addr[idx], 1'b0, wr_bank[idx], 18'h0, 0);
         end
      end

      // ---- REQ raised the cycle ref_pend rises (edge 400) -------------------
      while (cyc < 2 * RINT) step();
      access(20'h0F00F, 1'b1, 2'd2, 18'h1BEEF, 0);
      check("ref_before_access", {31'd0, saw_ref}, 32'd1);
      // refresh occupies edges 401..407, IDLE samples REQ at edge 409
      check("accept_after_ref", acc_cyc, 2 * RINT + 1 + ROWC + CASC + 1 + PREC + 1);
      access(20'h0F00F, 1'b0, 2'd2, 18'h0, 0);

      // ---- reset pulsed during COL of a write -------------------------------
      access(20'h3A1C7, 1'b1, 2'd0, 18'h15555, ROWC + 1);
      release_reset();
      access(20'h21234, 1'b1, 2'd0, 18'h0ACE1, 0);
      check("post_rst_first_acc", {31'd0, saw_ref}, 32'd0);
      access(20'h21234, 1'b0, 2'd0, 18'h0, 0);

      // refresh counter restarted from 199 at release
      while (cyc < RINT) step();
      check("post_rst_no_ref_yet", {23'd0, ctrl()}, {23'd0, ref_exp(cyc, RINT + 1)});
      step();
      check("post_rst_ref_cas", {23'd0, ctrl()}, {23'd0, ref_exp(cyc, RINT + 1)});
      step();
      check("post_rst_ref_ras", {23'd0, ctrl()}, {23'd0, ref_exp(cyc, RINT + 1)});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
